// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port and memory-side burst port of the cacheline adaptor.
// slave = adaptor view, master = the cache/memory environment driving it.
interface cacheline_adaptor_if #(
  parameter int s_line = 256,
  parameter int s_beat = 64
);
  logic [s_line-1:0] line_i;
  logic [s_line-1:0] line_o;
  logic [31:0]       address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [s_beat-1:0] burst_i;
  logic [s_beat-1:0] burst_o;
  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line request into a 4-beat 64-bit memory burst; optional ADAPTOR_PROTO_CHECK_EN adds sticky err_o.
// Latency: request edge + 4 beat edges -> DONE (resp_o one cycle); stalls when resp_i is low, requests held by cache until resp_o.
module cacheline_adaptor #(
  parameter int s_line    = 256,
  parameter int s_beat    = 64,
  parameter int num_beats = 4
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
`ifdef ADAPTOR_PROTO_CHECK_EN
  ,
  output logic                err_o
`endif
);

  localparam int cnt_w = $clog2(num_beats);
  localparam int off_w = $clog2(s_line / 8);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                            state;
  state_t                            state_nxt;
  logic [cnt_w-1:0]                  cnt;
  logic [31:0]                       addr_q;
  logic [num_beats-1:0][s_beat-1:0]  wr_buf;
  logic [num_beats-1:0][s_beat-1:0]  rd_line;
  logic                              beat_last;

  assign beat_last = bus.resp_i && (cnt == last_beat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.read_o  = 1'b0;
    bus.write_o = 1'b0;
    bus.resp_o  = 1'b0;
    case (state)
      IDLE: begin
        // write wins when both requests arrive together
        if (bus.write_i) begin
          state_nxt = WR_BURST;
        end else if (bus.read_i) begin
          state_nxt = RD_BURST;
        end
      end
      RD_BURST: begin
        bus.read_o = 1'b1;
        if (beat_last) begin
          state_nxt = DONE;
        end
      end
      WR_BURST: begin
        bus.write_o = 1'b1;
        if (beat_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.resp_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once at acceptance so later cache-side changes are harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wr_buf  <= '0;
      rd_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.write_i || bus.read_i) begin
            cnt    <= '0;
            addr_q <= {bus.address_i[31:off_w], {off_w{1'b0}}};
          end
          if (bus.write_i) begin
            wr_buf <= bus.line_i;
          end
        end
        RD_BURST: begin
          if (bus.resp_i) begin
            rd_line[cnt] <= bus.burst_i;
            cnt          <= cnt + cnt_w'(1);
          end
        end
        WR_BURST: begin
          if (bus.resp_i) begin
            cnt <= cnt + cnt_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.address_o = addr_q;
  assign bus.line_o    = rd_line;
  assign bus.burst_o   = (state == WR_BURST) ? wr_buf[cnt] : '0;

`ifdef ADAPTOR_PROTO_CHECK_EN
  logic rw_both;
  logic stray_resp;
  logic req_drop;
  logic err_q;

  assign rw_both    = (state == IDLE) && bus.read_i && bus.write_i;
  assign stray_resp = ((state == IDLE) || (state == DONE)) && bus.resp_i;
  assign req_drop   = ((state == RD_BURST) && !bus.read_i) ||
                      ((state == WR_BURST) && !bus.write_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (rw_both || stray_resp || req_drop) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      if (rw_both)    $error("cacheline_adaptor: read_i and write_i both high in IDLE");
      if (stray_resp) $error("cacheline_adaptor: resp_i high outside a burst");
      if (req_drop)   $error("cacheline_adaptor: request dropped mid-burst");
    end
  end
`endif
`endif

endmodule
